// File: rtl/sobel_frame_writer.sv
// -----------------------------------------------------------------------------
// sobel_frame_writer
//
// Captures the 8-bit Sobel result stream into an on-chip frame buffer in
// raster order. Row and column counters track the next write position
// alongside a linear pixel counter. When the last pixel is written, the block
// pulses frame_done. A registered read port drains the stored image.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous, active-high reset
//   start      : arm a new capture; clears counters and overflow
//   pix_in     : Sobel output pixel
//   pix_valid  : pix_in valid this cycle
//   busy       : high while capturing
//   frame_done : one-cycle pulse after the last pixel of the frame is written
//   overflow   : sticky; a pixel arrived after the frame was complete
//   row, col   : position of the next write
//   pix_count  : pixels written in this frame (also the write address)
//   rd_en      : read request
//   rd_addr    : linear read address (row*OUT_W+col)
//   rd_data    : read data, one cycle after rd_en
//   rd_valid   : rd_data valid this cycle
// -----------------------------------------------------------------------------
module sobel_frame_writer #(
  parameter int OUT_W  = 254,
  parameter int OUT_H  = 254,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        pix_in,
  input  logic              pix_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic [15:0]       row,
  output logic [15:0]       col,
  output logic [ADDR_W-1:0] pix_count,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              rd_valid
);

  localparam int DEPTH = OUT_W * OUT_H;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [7:0]        r_mem [0:DEPTH-1];
  logic [15:0]       r_row;
  logic [15:0]       r_col;
  logic [ADDR_W-1:0] r_pix_count;
  logic              r_frame_done;
  logic              r_overflow;
  logic [7:0]        r_rd_data;
  logic              r_rd_valid;

  logic w_accept;
  logic w_last;
  logic w_col_wrap;
  logic w_rd_in_range;
  logic w_overrun;

  // start always wins over a simultaneous pixel, so the pixel is neither
  // written nor counted as an overrun.
  assign w_accept      = (r_state == S_CAPTURE) && pix_valid && !start;
  assign w_col_wrap    = (r_col == 16'(OUT_W - 1));
  assign w_last        = w_accept && w_col_wrap && (r_row == 16'(OUT_H - 1));
  assign w_overrun     = (r_state == S_DONE) && pix_valid && !start;
  assign w_rd_in_range = (rd_addr < ADDR_W'(DEPTH));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (start) begin
      w_state_next = S_CAPTURE;
    end else begin
      case (r_state)
        S_CAPTURE: if (w_last) w_state_next = S_DONE;
        default:   w_state_next = r_state;
      endcase
    end
  end

  // Position counters and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row        <= '0;
      r_col        <= '0;
      r_pix_count  <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_frame_done <= w_last;
      if (start) begin
        r_row       <= '0;
        r_col       <= '0;
        r_pix_count <= '0;
        r_overflow  <= 1'b0;
      end else begin
        if (w_accept) begin
          r_pix_count <= r_pix_count + ADDR_W'(1);
          // On the final pixel this leaves row=OUT_H, col=0.
          if (w_col_wrap) begin
            r_col <= '0;
            r_row <= r_row + 16'd1;
          end else begin
            r_col <= r_col + 16'd1;
          end
        end
        if (w_overrun) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  // Frame buffer write port (contents are deliberately not reset)
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_pix_count[IDX_W-1:0]] <= pix_in;
    end
  end

  // Registered read port; the non-blocking write above makes a same-cycle
  // read of the written address return the previous contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= 8'd0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= w_rd_in_range ? r_mem[rd_addr[IDX_W-1:0]] : 8'd0;
      end
    end
  end

  assign busy       = (r_state == S_CAPTURE);
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;
  assign row        = r_row;
  assign col        = r_col;
  assign pix_count  = r_pix_count;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;

endmodule

// File: tb/tb_sobel_frame_writer.sv
// -----------------------------------------------------------------------------
// tb_sobel_frame_writer
//
// Self-checking bench for sobel_frame_writer with a 4x3 result frame. A
// behavioural model tracks the expected frame contents, pixel count, and
// flags. Each scenario task compares DUT outputs against that model.
// -----------------------------------------------------------------------------
module tb_sobel_frame_writer;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        busy;
  logic        frame_done;
  logic        overflow;
  logic [15:0] row;
  logic [15:0] col;
  logic [15:0] pix_count;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;

  sobel_frame_writer #(.OUT_W(W), .OUT_H(H), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .busy(busy), .frame_done(frame_done), .overflow(overflow), .row(row), .col(col),
    .pix_count(pix_count), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: 0 = idle, 1 = capturing, 2 = frame complete
  int         m_mode;
  int         m_count;
  logic       m_ovf;
  logic       m_fd;
  logic [7:0] m_mem [N];
  bit         m_known [N];
  logic [7:0] m_rd;
  bit         m_rd_known;
  logic       m_rv;

  task automatic model_reset();
    m_mode = 0; m_count = 0; m_ovf = 1'b0; m_fd = 1'b0;
    m_rd = 8'd0; m_rd_known = 1'b1; m_rv = 1'b0;
  endtask

  // Drive one clock cycle of stimulus, advance the model, and sample 1 time unit after the edge.
  task automatic cycle(input logic s, input logic v, input logic [7:0] p,
                       input logic re, input logic [15:0] ra);
    start = s; pix_valid = v; pix_in = p; rd_en = re; rd_addr = ra;
    m_rv = re;
    if (re) begin
      if (ra < N) begin
        m_rd = m_mem[ra];
        m_rd_known = m_known[ra];
      end else begin
        m_rd = 8'd0;
        m_rd_known = 1'b1;
      end
    end
    m_fd = 1'b0;
    if (s) begin
      m_mode = 1; m_count = 0; m_ovf = 1'b0;
    end else if (v) begin
      if (m_mode == 1) begin
        m_mem[m_count] = p; m_known[m_count] = 1'b1;
        m_count++;
        if (m_count == N) begin m_mode = 2; m_fd = 1'b1; end
      end else if (m_mode == 2) begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk); #1;
    $display("cyc t=%0t s=%0b v=%0b pix=%02h rd=%0b@%0d -> busy=%0b row=%0d col=%0d cnt=%0d fd=%0b ovf=%0b rdv=%0b rdd=%02h",
             $time, s, v, p, re, ra, busy, row, col, pix_count, frame_done, overflow, rd_valid, rd_data);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = 8'd0; rd_en = 1'b0; rd_addr = 16'd0;
    for (int i = 0; i < N; i++) m_known[i] = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b want 0", frame_done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    checks++; if (row !== 16'd0 || col !== 16'd0) begin errors++; $display("FAIL reset_rowcol: got %0d/%0d want 0/0", row, col); end
    checks++; if (pix_count !== 16'd0) begin errors++; $display("FAIL reset_pix_count: got %0d want 0", pix_count); end
    checks++; if (rd_data !== 8'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL reset_read: got %02h/%0b want 00/0", rd_data, rd_valid); end
    $display("test_reset done");
  endtask

  task automatic test_idle_pixels();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 8'($urandom), 1'b1, 16'(i));
      checks++; if (pix_count !== 16'd0) begin errors++; $display("FAIL idle_pix_count: got %0d want 0", pix_count); end
      checks++; if (overflow !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_flags: got ovf=%0b busy=%0b want 0/0", overflow, busy); end
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL idle_rd_valid: got %0b want 1", rd_valid); end
    end
    $display("test_idle_pixels done");
  endtask

  task automatic test_full_frame();
    int pulses;
    pulses = 0;
    cycle(1'b1, 1'b0, 8'd0, 1'b0, 16'd0);
    checks++; if (busy !== 1'b1 || pix_count !== 16'd0) begin errors++; $display("FAIL full_start: got busy=%0b cnt=%0d want 1/0", busy, pix_count); end
    for (int i = 0; i < N; i++) begin
      cycle(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 16'd0);
      if (frame_done === 1'b1) pulses++;
      checks++; if (frame_done !== m_fd) begin errors++; $display("FAIL full_frame_done px%0d: got %0b want %0b", i, frame_done, m_fd); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_end: got %0b want 0", busy); end
    cycle(1'b0, 1'b0, 8'd0, 1'b0, 16'd0);
    if (frame_done === 1'b1) pulses++;
    checks++; if (pulses != 1) begin errors++; $display("FAIL full_fd_pulses: got %0d want 1", pulses); end
    checks++; if (row !== 16'd3 || col !== 16'd0 || pix_count !== 16'(N)) begin
      errors++; $display("FAIL full_final_pos: got row=%0d col=%0d cnt=%0d want 3/0/%0d", row, col, pix_count, N); end
    for (int a = 0; a < N; a++) begin
      cycle(1'b0, 1'b0, 8'd0, 1'b1, 16'(a));
      checks++; if (rd_valid !== 1'b1 || rd_data !== 8'(8'h10 + a)) begin
        errors++; $display("FAIL full_read a%0d: got %02h/%0b want %02h/1", a, rd_data, rd_valid, 8'(8'h10 + a)); end
    end
    cycle(1'b0, 1'b0, 8'd0, 1'b0, 16'd0);
    checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h1B) begin errors++; $display("FAIL full_rd_hold: got %02h/%0b want 1b/0", rd_data, rd_valid); end
    $display("test_full_frame done");
  endtask

  task automatic test_gapped();
    int pulses;
    pulses = 0;
    cycle(1'b1, 1'b0, 8'd0, 1'b0, 16'd0);
    for (int k = 0; k < 2 * N + 2; k++) begin
      cycle(1'b0, 1'(k % 2), 8'($urandom), 1'b0, 16'd0);
      if (frame_done === 1'b1) pulses++;
      checks++; if (row !== 16'(m_count / W) || col !== 16'(m_count % W)) begin
        errors++; $display("FAIL gap_pos k%0d: got %0d/%0d want %0d/%0d", k, row, col, m_count / W, m_count % W); end
      checks++; if (frame_done !== m_fd) begin errors++; $display("FAIL gap_frame_done k%0d: got %0b want %0b", k, frame_done, m_fd); end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL gap_fd_pulses: got %0d want 1", pulses); end
    for (int a = 4; a < 8; a++) begin
      cycle(1'b0, 1'b0, 8'd0, 1'b1, 16'(a));
      checks++; if (rd_data !== m_rd) begin errors++; $display("FAIL gap_read a%0d: got %02h want %02h", a, rd_data, m_rd); end
    end
    $display("test_gapped done");
  endtask

  task automatic test_overflow_restart();
    logic [7:0] old0;
    old0 = m_mem[0];
    cycle(1'b0, 1'b1, 8'hFF, 1'b0, 16'd0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b want 1", overflow); end
    cycle(1'b0, 1'b0, 8'd0, 1'b1, 16'd0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
    checks++; if (rd_data !== old0) begin errors++; $display("FAIL ovf_addr0: got %02h want %02h", rd_data, old0); end
    cycle(1'b1, 1'b0, 8'd0, 1'b0, 16'd0);
    checks++; if (overflow !== 1'b0 || pix_count !== 16'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL ovf_restart: got ovf=%0b cnt=%0d busy=%0b want 0/0/1", overflow, pix_count, busy); end
    cycle(1'b0, 1'b1, 8'hAA, 1'b0, 16'd0);
    cycle(1'b0, 1'b0, 8'd0, 1'b1, 16'd0);
    checks++; if (rd_data !== 8'hAA) begin errors++; $display("FAIL ovf_first_pixel: got %02h want aa", rd_data); end
    $display("test_overflow_restart done");
  endtask

  task automatic test_collision_oob();
    logic [7:0] old2;
    cycle(1'b1, 1'b1, 8'h77, 1'b0, 16'd0);
    checks++; if (pix_count !== 16'd0) begin errors++; $display("FAIL start_wins: got cnt=%0d want 0", pix_count); end
    cycle(1'b0, 1'b1, 8'($urandom), 1'b0, 16'd0);
    cycle(1'b0, 1'b1, 8'($urandom), 1'b0, 16'd0);
    old2 = m_mem[2];
    cycle(1'b0, 1'b1, 8'h55, 1'b1, 16'd2);
    checks++; if (rd_data !== old2) begin errors++; $display("FAIL collision_old: got %02h want %02h", rd_data, old2); end
    cycle(1'b0, 1'b0, 8'd0, 1'b1, 16'd2);
    checks++; if (rd_data !== 8'h55) begin errors++; $display("FAIL collision_new: got %02h want 55", rd_data); end
    cycle(1'b0, 1'b0, 8'd0, 1'b1, 16'd12);
    checks++; if (rd_data !== 8'd0 || rd_valid !== 1'b1) begin errors++; $display("FAIL oob_12: got %02h/%0b want 00/1", rd_data, rd_valid); end
    cycle(1'b0, 1'b0, 8'd0, 1'b1, 16'd1);
    cycle(1'b0, 1'b0, 8'd0, 1'b1, 16'd200);
    checks++; if (rd_data !== 8'd0 || rd_valid !== 1'b1) begin errors++; $display("FAIL oob_200: got %02h/%0b want 00/1", rd_data, rd_valid); end
    $display("test_collision_oob done");
  endtask

  task automatic test_midframe_reset();
    cycle(1'b1, 1'b0, 8'd0, 1'b0, 16'd0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b1, 16'(i));
    start = 1'b0; pix_valid = 1'b0; rd_en = 1'b0;
    #3 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || frame_done !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL midrst_flags: got busy=%0b fd=%0b ovf=%0b want 0/0/0", busy, frame_done, overflow); end
    checks++; if (row !== 16'd0 || col !== 16'd0 || pix_count !== 16'd0) begin
      errors++; $display("FAIL midrst_counters: got %0d/%0d/%0d want 0/0/0", row, col, pix_count); end
    checks++; if (rd_data !== 8'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL midrst_read: got %02h/%0b want 00/0", rd_data, rd_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 8'($urandom), 1'b0, 16'd0);
      checks++; if (pix_count !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: got cnt=%0d busy=%0b want 0/0", pix_count, busy); end
    end
    for (int a = 0; a < N; a++) begin
      cycle(1'b0, 1'b0, 8'd0, 1'b1, 16'(a));
      if (m_rd_known) begin
        checks++; if (rd_data !== m_rd) begin errors++; $display("FAIL midrst_mem a%0d: got %02h want %02h", a, rd_data, m_rd); end
      end
    end
    cycle(1'b1, 1'b0, 8'd0, 1'b0, 16'd0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_restart: got %0b want 1", busy); end
    $display("test_midframe_reset done");
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      cycle(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 16'd0);
      for (int k = 0; k < 40; k++) begin
        cycle(1'b0, 1'($urandom_range(0, 9) < 6), 8'($urandom), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 13)));
        checks++; if (busy !== 1'(m_mode == 1)) begin errors++; $display("FAIL rnd_busy f%0d k%0d: got %0b want %0b", f, k, busy, m_mode == 1); end
        checks++; if (row !== 16'(m_count / W) || col !== 16'(m_count % W) || pix_count !== 16'(m_count)) begin
          errors++; $display("FAIL rnd_pos f%0d k%0d: got %0d/%0d/%0d want %0d/%0d/%0d", f, k, row, col, pix_count, m_count / W, m_count % W, m_count); end
        checks++; if (frame_done !== m_fd || overflow !== m_ovf) begin
          errors++; $display("FAIL rnd_flags f%0d k%0d: got fd=%0b ovf=%0b want %0b/%0b", f, k, frame_done, overflow, m_fd, m_ovf); end
        checks++; if (rd_valid !== m_rv) begin errors++; $display("FAIL rnd_rd_valid f%0d k%0d: got %0b want %0b", f, k, rd_valid, m_rv); end
        if (m_rd_known) begin
          checks++; if (rd_data !== m_rd) begin errors++; $display("FAIL rnd_rd_data f%0d k%0d: got %02h want %02h", f, k, rd_data, m_rd); end
        end
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_idle_pixels();
    test_full_frame();
    test_gapped();
    test_overflow_restart();
    test_collision_oob();
    test_midframe_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_frame_writer.md
# sobel_frame_writer

Sink-side counterpart of the Sobel window source. It captures the 8-bit Sobel output pixel stream (`bus_out` of `main_sobel`) into an on-chip result frame buffer in raster order, tracking row and column. When the frame is complete it flags completion. A registered read port then lets a host or bench drain the result image. It sits directly downstream of `main_sobel` and replaces the file-dump path for on-chip result checking.

## Interface
- `OUT_W`, default 254: result image width in pixels (input width minus 2).
- `OUT_H`, default 254: result image height in pixels.
- `ADDR_W`, default 16: address width; must satisfy 2^ADDR_W >= OUT_W*OUT_H.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: arms a new capture and clears counters and flags.
- `pix_in` in 8: Sobel output pixel.
- `pix_valid` in 1: `pix_in` is valid this cycle.
- `busy` out 1: high while in CAPTURE.
- `frame_done` out 1: one-cycle pulse after the last pixel is written.
- `overflow` out 1: sticky flag; a pixel arrived while the block was in DONE.
- `row` out 16: row index of the next write.
- `col` out 16: column index of the next write.
- `pix_count` out ADDR_W: number of pixels written in this frame.
- `rd_en` in 1: read request.
- `rd_addr` in ADDR_W: linear read address, computed as row*OUT_W+col.
- `rd_data` out 8: read data.
- `rd_valid` out 1: `rd_data` is valid this cycle.

## Operation
- The memory is OUT_W*OUT_H bytes. The write address is `pix_count`, a linear counter. `row` and `col` are maintained alongside it, not derived by multiplication.
- The state machine has three states: IDLE, CAPTURE, DONE.
- IDLE:
  - `pix_valid` is ignored: no write, no flag.
  - `start` moves the block to CAPTURE.
- CAPTURE, on each `pix_valid`:
  - mem[pix_count] <= pix_in; pix_count++.
  - col++; if col == OUT_W-1, col <= 0 and row++.
- Last pixel (row==OUT_H-1, col==OUT_W-1, `pix_valid` high):
  - The pixel is written.
  - The state moves to DONE.
  - `row`, `col` and `pix_count` hold their final increments: row=OUT_H, col=0, pix_count=OUT_W*OUT_H.
- DONE:
  - `pix_valid` is not written and sets `overflow`.
  - `start` moves the block to CAPTURE.
- `start` in any state clears row, col, pix_count and overflow, and enters CAPTURE.
- `start` and `pix_valid` in the same cycle: `start` wins and that pixel is dropped, with no write and no flag.
- Read port, active in every state:
  - `rd_en` at cycle N gives `rd_data` = mem[rd_addr] and `rd_valid`=1 at cycle N+1.
  - `rd_valid`=0 when `rd_en` was low; `rd_data` holds its last value.
  - rd_addr >= OUT_W*OUT_H returns 0 with `rd_valid`=1.
- Read/write collision: a read of the address being written in the same cycle returns the old contents (read-first).

## Timing
- Reset values: state=IDLE, busy=0, frame_done=0, overflow=0, row=0, col=0, pix_count=0, rd_data=0, rd_valid=0. Memory contents are not reset.
- `rst` asserted mid-capture aborts immediately. After release the block sits in IDLE; a new `start` is required.
- `start` at cycle N gives busy=1 at N+1. The first pixel can be accepted at N+1.
- Write latency: a pixel accepted at cycle N is readable by a read issued at N+1 or later.
- The last pixel accepted at cycle N gives frame_done=1 during N+1 only, with busy=0 from N+1.
- Throughput: one pixel per cycle, sustained. There is no backpressure; `pix_valid` gaps of any length are allowed.
- `overflow` sets at the cycle after the offending pixel and stays set until `start` or `rst`.

## Test plan
Directed scenarios, all with OUT_W=4, OUT_H=3 unless stated.
- Reset then idle pixels: pulse rst, drive 5 pixels with no `start` -> pix_count=0, overflow=0, busy=0, reads of addresses 0..11 never hit a written value.
- Full frame: `start`, then 12 back-to-back pixels 8'h10..8'h1B -> frame_done pulses once, on the cycle after the 12th pixel. Reading addresses 0..11 returns 10..1B with 1-cycle latency. row=3, col=0 at the end.
- Gapped stream with wrap: `start`, pixels with `pix_valid` toggling every other cycle -> after the 4th pixel row=1, col=0. Addresses 4..7 hold pixels 5..8. frame_done occurs after 12 accepted pixels.
- Overflow and restart:
  - After DONE, send 1 pixel 8'hFF -> overflow=1, address 0 unchanged.
  - Then pulse `start` -> overflow=0, pix_count=0.
  - The next pixel 8'hAA lands at address 0.
- Collision and out-of-range reads:
  - Write 8'h55 to address 2 while reading address 2 the same cycle -> old value returned; a read on the next cycle returns 55.
  - A read of address 12 -> rd_data=0, rd_valid=1.
- Mid-frame reset: after 6 pixels, assert rst asynchronously between clock edges -> all outputs 0 immediately, state IDLE. Pixels are ignored until `start`.
